// File: rtl/char_scroll_sequencer_if.sv
// Bus bundle between a message source and the scrolling character sequencer.
// The master drives buffer writes and scroll control; the slave returns display-stage strobes.
interface char_scroll_sequencer_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] msg_len;
    logic       run;
    logic       refresh;
    logic [3:0] data;
    logic [1:0] char_position;
    logic       load;
    logic [3:0] window_start;
    logic       busy;

    modport master (
        output wr_en, wr_addr, wr_data, msg_len, run, refresh,
        input  data, char_position, load, window_start, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len, run, refresh,
        output data, char_position, load, window_start, busy
    );
endinterface

// File: rtl/char_scroll_sequencer.sv
// Scrolls a 16-entry character message through a 4-slot display, one window step per
// prescaler tick, emitting a 4-cycle load burst per redraw.
module char_scroll_sequencer_chk (
    input logic       clk,
    input logic       reset,
    input logic       load,
    input logic       busy,
    input logic [1:0] char_position
);
    logic       prev_load_r;
    logic [1:0] prev_pos_r;

    // Remember the previous strobe so burst continuity can be checked.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_load_r <= 1'b0;
            prev_pos_r  <= 2'd0;
        end else begin
            prev_load_r <= load;
            prev_pos_r  <= char_position;
        end
    end

    // Load and busy always coincide; a burst never stops before slot 3.
    always @(posedge clk) begin
        if (!reset) begin
            assert (load == busy);
            if (prev_load_r && (prev_pos_r != 2'd3)) begin
                assert (load && (char_position == prev_pos_r + 2'd1));
            end
        end
    end
endmodule

module char_scroll_sequencer #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    char_scroll_sequencer_if.slave bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_REFRESH = 1'b1;
    localparam int         DEPTH      = 16;

    logic [3:0]  mem_r [DEPTH];
    logic [23:0] cnt_r;
    logic [0:0]  state_r;
    logic [1:0]  step_r;
    logic [3:0]  rd_ptr_r;
    logic [3:0]  window_start_r;
    logic [3:0]  data_r;
    logic [1:0]  char_position_r;
    logic        pending_r;
    logic        load_r;
    logic        busy_r;

    logic        tick_s;
    logic        start_s;
    logic [3:0]  ws_next_s;
    logic [3:0]  rd_src_s;
    logic [3:0]  rd_adv_s;

    // Prescaler tick and the decision whether a redraw burst starts this cycle.
    always_comb begin
        tick_s    = 1'b0;
        start_s   = 1'b0;
        ws_next_s = window_start_r;
        if (bus.run && (cnt_r == MAX_COUNT - 24'd1)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (tick_s || pending_r) begin
                    start_s   = 1'b1;
                    ws_next_s = (window_start_r >= bus.msg_len) ? 4'd0 : window_start_r + 4'd1;
                end else if (bus.refresh) begin
                    // A shortened message may leave the window past its end.
                    start_s   = 1'b1;
                    ws_next_s = (window_start_r > bus.msg_len) ? 4'd0 : window_start_r;
                end else begin
                    start_s   = 1'b0;
                    ws_next_s = window_start_r;
                end
            end
            default: begin
                start_s   = 1'b0;
                ws_next_s = window_start_r;
            end
        endcase
    end

    // Buffer index for the slot registered this edge, and its wrapped successor.
    always_comb begin
        rd_src_s = rd_ptr_r;
        rd_adv_s = 4'd0;
        if (start_s) begin
            rd_src_s = ws_next_s;
        end else begin
            rd_src_s = rd_ptr_r;
        end
        if (rd_src_s == bus.msg_len) begin
            rd_adv_s = 4'd0;
        end else begin
            rd_adv_s = rd_src_s + 4'd1;
        end
    end

    // Scroll prescaler: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 24'd0;
        end else if (!bus.run) begin
            cnt_r <= 24'd0;
        end else if (cnt_r == MAX_COUNT - 24'd1) begin
            cnt_r <= 24'd0;
        end else begin
            cnt_r <= cnt_r + 24'd1;
        end
    end

    // Message buffer; reads elsewhere see the pre-write contents on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 4'd0;
            end
        end else if (bus.wr_en) begin
            mem_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sequencer: the start edge registers slot 0, each REFRESH cycle registers the next slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            step_r          <= 2'd0;
            rd_ptr_r        <= 4'd0;
            window_start_r  <= 4'd0;
            pending_r       <= 1'b0;
            load_r          <= 1'b0;
            data_r          <= 4'd0;
            char_position_r <= 2'd0;
            busy_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    window_start_r <= ws_next_s;
                    if (start_s) begin
                        state_r         <= ST_REFRESH;
                        step_r          <= 2'd0;
                        pending_r       <= 1'b0;
                        load_r          <= 1'b1;
                        busy_r          <= 1'b1;
                        char_position_r <= 2'd0;
                        data_r          <= mem_r[rd_src_s];
                        rd_ptr_r        <= rd_adv_s;
                    end else begin
                        load_r <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_REFRESH: begin
                    if (tick_s) begin
                        pending_r <= 1'b1;
                    end
                    if (step_r == 2'd3) begin
                        state_r <= ST_IDLE;
                        load_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        step_r          <= step_r + 2'd1;
                        load_r          <= 1'b1;
                        busy_r          <= 1'b1;
                        char_position_r <= step_r + 2'd1;
                        data_r          <= mem_r[rd_src_s];
                        rd_ptr_r        <= rd_adv_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    load_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data          = data_r;
    assign bus.char_position = char_position_r;
    assign bus.load          = load_r;
    assign bus.window_start  = window_start_r;
    assign bus.busy          = busy_r;

    char_scroll_sequencer_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .load          (load_r),
        .busy          (busy_r),
        .char_position (char_position_r)
    );
endmodule

// File: doc/char_scroll_sequencer.md
CHAR_SCROLL_SEQUENCER -- requirements
Module: char_scroll_sequencer

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 24'd10_000_000, meaning clk cycles per scroll tick; legal range 8..2^24-1.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  message-buffer write strobe.
REQ-005 SHALL have port wr_addr  input  4  message-buffer write address.
REQ-006 SHALL have port wr_data  input  4  character code written.
REQ-007 SHALL have port msg_len  input  4  message length minus one (1..16 chars).
REQ-008 SHALL have port run  input  1  scroll enable.
REQ-009 SHALL have port refresh  input  1  single-cycle request to redraw the current window without advancing.
REQ-010 SHALL have port data  output  4  character code to display stage, registered.
REQ-011 SHALL have port char_position  output  2  display slot 0..3, registered.
REQ-012 SHALL have port load  output  1  write strobe to display stage, registered.
REQ-013 SHALL have port window_start  output  4  buffer index shown in slot 0.
REQ-014 SHALL have port busy  output  1  high while in REFRESH.

Function
REQ-015 SHALL hold a 16 x 4-bit message buffer; wr_en=1 writes wr_data to mem[wr_addr] at the clock edge, in any state.
REQ-016 SHALL read-before-write: a buffer read and write to the same address in one cycle returns the old value.
REQ-017 SHALL run a 24-bit prescaler: while run=1 it counts 0..MAX_COUNT-1 and wraps; the cycle where count==MAX_COUNT-1 is a tick.
REQ-018 SHALL hold the prescaler at 0 while run=0; no ticks then; window_start frozen.
REQ-019 SHALL implement FSM states IDLE and REFRESH; reset state IDLE.
REQ-020 SHALL, in IDLE on tick or pending tick: window_start <= (window_start>=msg_len) ? 0 : window_start+1, clear pending, enter REFRESH.
REQ-021 SHALL, in IDLE on refresh=1 (no tick): keep window_start (forced to 0 if window_start>msg_len), enter REFRESH.
REQ-022 SHALL give tick precedence over refresh in the same cycle (one REFRESH, with advance).
REQ-023 SHALL, on REFRESH entry, load read pointer rd_ptr with the new window_start.
REQ-024 SHALL spend exactly 4 cycles in REFRESH, step k=0..3; each step registers load=1, char_position=k, data=mem[rd_ptr], then rd_ptr <= (rd_ptr==msg_len) ? 0 : rd_ptr+1.
REQ-025 SHALL therefore assert load for exactly 4 consecutive cycles, the first being the cycle after the tick/refresh cycle; load=0 at all other times.
REQ-026 SHALL hold data and char_position at their last values when load=0.
REQ-027 SHALL return to IDLE after step 3; busy=1 exactly during the 4 REFRESH cycles.
REQ-028 SHALL latch a tick occurring during REFRESH into a 1-bit pending flag serviced on return to IDLE; further ticks while pending=1 are dropped.
REQ-029 SHALL ignore refresh while in REFRESH.
REQ-030 SHALL sample msg_len each cycle; a change mid-REFRESH affects wrap of remaining steps only.
REQ-031 SHALL repeat characters when msg_len<3 (e.g. msg_len=0 shows mem[0] in all 4 slots).

Reset
REQ-032 SHALL, when reset=1 at a clock edge, set prescaler=0, window_start=0, rd_ptr=0, pending=0, state=IDLE, load=0, data=0, char_position=0, busy=0, all 16 buffer entries=0.
REQ-033 SHALL let reset override all inputs including wr_en; reset mid-REFRESH aborts with no further load pulses.

Verification (bench MAX_COUNT=8)
REQ-034 Write mem[0..5]=1,2,3,4,5,6, msg_len=5, pulse refresh -> load high 4 cycles, (pos,data)=(0,1),(1,2),(2,3),(3,4), window_start=0.
REQ-035 Same buffer, run=1 for 8 cycles -> tick; window_start=1; slots show 2,3,4,5; after 5 more ticks window_start wraps 5->0, slots show 1,2,3,4; window_start=4 shows 5,6,1,2.
REQ-036 msg_len=1, mem[0]=A, mem[1]=B, refresh -> slots A,B,A,B; msg_len=0 -> A,A,A,A.
REQ-037 Tick coincident with refresh -> single 4-cycle burst with advanced window; tick forced during REFRESH -> second burst starts the cycle after busy falls.
REQ-038 Write mem[2]=F in the cycle step 2 registers -> slot 2 shows old value; next burst shows F.
REQ-039 Assert reset during step 1 of a burst -> next cycle load=0, busy=0, window_start=0, all buffer reads 0.
